game_flow_controller: RTL and testbench
=======================================

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter START_LIVES, default 3, lives loaded at game start (1..3).
REQ-002 Parameter MAX_LEVEL, default 9, highest level number; level saturates here.
REQ-003 Parameter INTRO_FRAMES, default 60, frames spent in LEVEL_INTRO.
REQ-004 Parameter DEATH_FRAMES, default 90, frames spent in PLAYER_DEAD.
REQ-005 Parameter CLEAR_FRAMES, default 60, frames spent in LEVEL_CLEAR.
REQ-006 Parameter OVER_FRAMES, default 180, frames spent in GAME_OVER.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-010 start_key  in  1  one-cycle pulse: start key make event from keyboard path.
REQ-011 player_hit  in  1  one-cycle pulse: player collided with monster or monster missile.
REQ-012 monsters_cleared  in  1  level: every monster in the wave is destroyed.
REQ-013 monsters_landed  in  1  level: a monster reached the player row.
REQ-014 game_state  out  3  current state encoding (package enum).
REQ-015 game_active  out  1  high only in PLAYING; enables player, monsters, missiles movement.
REQ-016 round_reset  out  1  one-cycle pulse re-initialising player, monsters, missiles positions.
REQ-017 level  out  4  current level, 1..MAX_LEVEL.
REQ-018 lives  out  2  remaining lives, 0..START_LIVES.
REQ-019 banner_sel  out  2  overlay select: 0 none, 1 title, 2 level banner, 3 game over.

Function
REQ-020 States: IDLE, LEVEL_INTRO, PLAYING, PLAYER_DEAD, LEVEL_CLEAR, GAME_OVER.
REQ-021 IDLE: start_key -> LEVEL_INTRO with level=1, lives=START_LIVES, round_reset pulsed.
REQ-022 Timed states hold for exactly N startOfFrame pulses after entry: timer loaded N-1 on entry, decremented per pulse, exit on pulse seen with timer==0.
REQ-023 LEVEL_INTRO exits to PLAYING after INTRO_FRAMES.
REQ-024 PLAYING: player_hit or monsters_landed -> lives decremented; lives becoming 0 -> GAME_OVER, else PLAYER_DEAD.
REQ-025 PLAYING: monsters_cleared (no simultaneous hit/landed) -> LEVEL_CLEAR.
REQ-026 Simultaneous hit/landed and monsters_cleared in one cycle: death path wins; lives decrement once only.
REQ-027 PLAYER_DEAD exits to LEVEL_INTRO after DEATH_FRAMES, same level, round_reset pulsed on that transition.
REQ-028 LEVEL_CLEAR exits to LEVEL_INTRO after CLEAR_FRAMES; level incremented, saturating at MAX_LEVEL; round_reset pulsed.
REQ-029 GAME_OVER exits to IDLE after OVER_FRAMES; start_key in GAME_OVER ignored.
REQ-030 Event inputs ignored outside PLAYING; start_key ignored outside IDLE.
REQ-031 round_reset high exactly one cycle, the cycle after the transition edge into LEVEL_INTRO.
REQ-032 All outputs registered; state and outputs update one clk after the qualifying input.
REQ-033 banner_sel: IDLE 1, LEVEL_INTRO 2, GAME_OVER 3, else 0.

Reset
REQ-034 rst -> IDLE, game_active 0, round_reset 0, level 1, lives START_LIVES, banner_sel 1, timer 0.
REQ-035 rst mid-state (any timed state, any timer value) aborts immediately to reset values; no round_reset pulse.

Structure
REQ-036 Shared package game_pkg holds state enum typedef, LEVEL_WIDTH=4, LIVES_WIDTH=2, banner_sel codes.
REQ-037 One sub-module frame_timer: load value, startOfFrame decrement, expired flag.

Verification
REQ-038 rst, start_key at cycle 10 -> LEVEL_INTRO, round_reset one cycle, level=1, lives=3; PLAYING after exactly 60 startOfFrame pulses.
REQ-039 PLAYING, player_hit x3 each after respawn -> lives 2,1 via PLAYER_DEAD (90 frames each), third hit -> GAME_OVER, lives=0, IDLE after 180 frames.
REQ-040 PLAYING, player_hit and monsters_cleared same cycle -> PLAYER_DEAD, lives 3->2, level unchanged.
REQ-041 MAX_LEVEL=2: clear level 1 -> level 2; clear level 2 -> level stays 2 after LEVEL_CLEAR 60 frames.
REQ-042 rst asserted in LEVEL_CLEAR with timer=20 -> next cycle IDLE, level=1, lives=3, no round_reset.
REQ-043 start_key during PLAYING and GAME_OVER, player_hit during LEVEL_INTRO -> no state, lives or level change.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types, widths and overlay codes for the game flow controller
package game_pkg;
  localparam int LEVEL_WIDTH = 4;
  localparam int LIVES_WIDTH = 2;
  localparam int TIMER_WIDTH = 16;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEVEL_INTRO,
    ST_PLAYING,
    ST_PLAYER_DEAD,
    ST_LEVEL_CLEAR,
    ST_GAME_OVER
  } game_state_t;
  localparam logic [1:0] BANNER_NONE  = 2'd0;
  localparam logic [1:0] BANNER_TITLE = 2'd1;
  localparam logic [1:0] BANNER_LEVEL = 2'd2;
  localparam logic [1:0] BANNER_OVER  = 2'd3;
  function automatic logic [1:0] banner_for(input game_state_t s);
    return s == ST_IDLE        ? BANNER_TITLE :
           s == ST_LEVEL_INTRO ? BANNER_LEVEL :
           s == ST_GAME_OVER   ? BANNER_OVER  : BANNER_NONE;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter stepped by frame pulses, flags when it sits at zero
module frame_timer
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_val,
  input  logic                   sof,
  output logic                   expired
);
  logic [TIMER_WIDTH-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (sof && cnt != '0) cnt <= cnt - TIMER_WIDTH'(1);
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: title/intro/play/death/clear/game-over sequencing with lives and level tracking
module game_flow_controller
  import game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int MAX_LEVEL    = 9,
  parameter int INTRO_FRAMES = 60,
  parameter int DEATH_FRAMES = 90,
  parameter int CLEAR_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startOfFrame,
  input  logic                   start_key,
  input  logic                   player_hit,
  input  logic                   monsters_cleared,
  input  logic                   monsters_landed,
  output game_state_t            game_state,
  output logic                   game_active,
  output logic                   round_reset,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic [1:0]             banner_sel
);
  game_state_t            state_n;
  logic [LEVEL_WIDTH-1:0] level_n;
  logic [LIVES_WIDTH-1:0] lives_n;
  logic                   load, expired, tick, died;
  logic [TIMER_WIDTH-1:0] load_val;

  frame_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .sof      (startOfFrame),
    .expired  (expired)
  );

  assign tick = startOfFrame && expired;
  assign died = player_hit || monsters_landed;

  // Every timed state is entered with its frame count minus one so it lasts exactly N pulses.
  always_comb begin
    state_n  = game_state;
    level_n  = level;
    lives_n  = lives;
    load     = 1'b0;
    load_val = '0;
    case (game_state)
      ST_IDLE: if (start_key) begin
        state_n  = ST_LEVEL_INTRO;
        level_n  = LEVEL_WIDTH'(1);
        lives_n  = LIVES_WIDTH'(START_LIVES);
        load     = 1'b1;
        load_val = TIMER_WIDTH'(INTRO_FRAMES - 1);
      end
      ST_LEVEL_INTRO: if (tick) state_n = ST_PLAYING;
      ST_PLAYING: if (died) begin
        lives_n  = lives - LIVES_WIDTH'(1);
        state_n  = lives == LIVES_WIDTH'(1) ? ST_GAME_OVER : ST_PLAYER_DEAD;
        load     = 1'b1;
        load_val = lives == LIVES_WIDTH'(1) ? TIMER_WIDTH'(OVER_FRAMES - 1)
                                            : TIMER_WIDTH'(DEATH_FRAMES - 1);
      end else if (monsters_cleared) begin
        state_n  = ST_LEVEL_CLEAR;
        load     = 1'b1;
        load_val = TIMER_WIDTH'(CLEAR_FRAMES - 1);
      end
      ST_PLAYER_DEAD: if (tick) begin
        state_n  = ST_LEVEL_INTRO;
        load     = 1'b1;
        load_val = TIMER_WIDTH'(INTRO_FRAMES - 1);
      end
      ST_LEVEL_CLEAR: if (tick) begin
        state_n  = ST_LEVEL_INTRO;
        level_n  = level == LEVEL_WIDTH'(MAX_LEVEL) ? level : level + LEVEL_WIDTH'(1);
        load     = 1'b1;
        load_val = TIMER_WIDTH'(INTRO_FRAMES - 1);
      end
      ST_GAME_OVER: if (tick) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      game_state  <= ST_IDLE;
      level       <= LEVEL_WIDTH'(1);
      lives       <= LIVES_WIDTH'(START_LIVES);
      game_active <= 1'b0;
      round_reset <= 1'b0;
      banner_sel  <= BANNER_TITLE;
    end else begin
      game_state  <= state_n;
      level       <= level_n;
      lives       <= lives_n;
      game_active <= state_n == ST_PLAYING;
      round_reset <= state_n == ST_LEVEL_INTRO && game_state != ST_LEVEL_INTRO;
      banner_sel  <= banner_for(state_n);
    end
  end
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed scenario checks of the game flow controller
module tb_game_flow_controller;
  import game_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sof = 1'b0, start_key = 1'b0, player_hit = 1'b0, cleared = 1'b0, landed = 1'b0;
  game_state_t game_state;
  logic game_active, round_reset;
  logic [3:0] level;
  logic [1:0] lives, banner_sel;
  logic [12:0] obs, e;
  int n_cmp = 0;
  int n_bad = 0;

  game_flow_controller #(.MAX_LEVEL(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .startOfFrame     (sof),
    .start_key        (start_key),
    .player_hit       (player_hit),
    .monsters_cleared (cleared),
    .monsters_landed  (landed),
    .game_state       (game_state),
    .game_active      (game_active),
    .round_reset      (round_reset),
    .level            (level),
    .lives            (lives),
    .banner_sel       (banner_sel)
  );

  always #5 clk = ~clk;
  assign obs = {game_state, game_active, round_reset, level, lives, banner_sel};

  function automatic logic [12:0] ev(input game_state_t s, input logic a, input logic r,
                                     input logic [3:0] lv, input logic [1:0] li, input logic [1:0] b);
    return {s, a, r, lv, li, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sof = 1'b1;
      tick();
      sof = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    e = ev(ST_IDLE, 0, 0, 1, 3, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL reset got=%h exp=%h", obs, e); end
  endtask

  task automatic test_start();
    repeat (6) tick();
    start_key = 1'b1; tick(); start_key = 1'b0;
    e = ev(ST_LEVEL_INTRO, 0, 1, 1, 3, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL start_intro got=%h exp=%h", obs, e); end
    tick();
    e = ev(ST_LEVEL_INTRO, 0, 0, 1, 3, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL round_reset_width got=%h exp=%h", obs, e); end
    frames(59);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL intro_59 got=%h exp=%h", obs, e); end
    frames(1);
    e = ev(ST_PLAYING, 1, 0, 1, 3, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL intro_60 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_hits();
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    e = ev(ST_PLAYER_DEAD, 0, 0, 1, 2, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hit1 got=%h exp=%h", obs, e); end
    frames(89);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL dead_89 got=%h exp=%h", obs, e); end
    frames(1);
    e = ev(ST_LEVEL_INTRO, 0, 1, 1, 2, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL dead_90 got=%h exp=%h", obs, e); end
    frames(60);
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    e = ev(ST_PLAYER_DEAD, 0, 0, 1, 1, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hit2 got=%h exp=%h", obs, e); end
    frames(90);
    frames(60);
    e = ev(ST_PLAYING, 1, 0, 1, 1, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL respawn2 got=%h exp=%h", obs, e); end
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    e = ev(ST_GAME_OVER, 0, 0, 1, 0, 3);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hit3_over got=%h exp=%h", obs, e); end
    start_key = 1'b1; tick(); start_key = 1'b0;
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL start_in_over got=%h exp=%h", obs, e); end
    frames(179);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL over_179 got=%h exp=%h", obs, e); end
    frames(1);
    e = ev(ST_IDLE, 0, 0, 1, 0, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL over_180 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_simultaneous();
    start_key = 1'b1; tick(); start_key = 1'b0;
    e = ev(ST_LEVEL_INTRO, 0, 1, 1, 3, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL restart got=%h exp=%h", obs, e); end
    frames(60);
    start_key = 1'b1; tick(); start_key = 1'b0;
    e = ev(ST_PLAYING, 1, 0, 1, 3, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL start_in_play got=%h exp=%h", obs, e); end
    player_hit = 1'b1; cleared = 1'b1; tick(); player_hit = 1'b0; cleared = 1'b0;
    e = ev(ST_PLAYER_DEAD, 0, 0, 1, 2, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hit_and_clear got=%h exp=%h", obs, e); end
    frames(90);
    player_hit = 1'b1; landed = 1'b1; tick(); player_hit = 1'b0; landed = 1'b0;
    e = ev(ST_LEVEL_INTRO, 0, 0, 1, 2, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hit_in_intro got=%h exp=%h", obs, e); end
    frames(60);
    e = ev(ST_PLAYING, 1, 0, 1, 2, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL play_after_intro got=%h exp=%h", obs, e); end
  endtask

  task automatic test_level_clear();
    cleared = 1'b1; tick(); cleared = 1'b0;
    e = ev(ST_LEVEL_CLEAR, 0, 0, 1, 2, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL clear1 got=%h exp=%h", obs, e); end
    frames(59);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL clear_59 got=%h exp=%h", obs, e); end
    frames(1);
    e = ev(ST_LEVEL_INTRO, 0, 1, 2, 2, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL level2 got=%h exp=%h", obs, e); end
    frames(60);
    cleared = 1'b1; tick(); cleared = 1'b0;
    frames(60);
    e = ev(ST_LEVEL_INTRO, 0, 1, 2, 2, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL level_sat got=%h exp=%h", obs, e); end
    frames(60);
    landed = 1'b1; tick(); landed = 1'b0;
    e = ev(ST_PLAYER_DEAD, 0, 0, 2, 1, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL landed got=%h exp=%h", obs, e); end
  endtask

  task automatic test_rst_mid();
    frames(90);
    frames(60);
    cleared = 1'b1; tick(); cleared = 1'b0;
    frames(39);
    e = ev(ST_LEVEL_CLEAR, 0, 0, 2, 1, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL clear_t20 got=%h exp=%h", obs, e); end
    rst = 1'b1; tick(); rst = 1'b0;
    e = ev(ST_IDLE, 0, 0, 1, 3, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL rst_mid got=%h exp=%h", obs, e); end
    cleared = 1'b1; player_hit = 1'b1; sof = 1'b1; tick(); cleared = 1'b0; player_hit = 1'b0; sof = 1'b0;
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL idle_ignore got=%h exp=%h", obs, e); end
    start_key = 1'b1; tick(); start_key = 1'b0;
    frames(59);
    e = ev(ST_LEVEL_INTRO, 0, 0, 1, 3, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL post_rst_59 got=%h exp=%h", obs, e); end
    frames(1);
    e = ev(ST_PLAYING, 1, 0, 1, 3, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL post_rst_60 got=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits();
    test_simultaneous();
    test_level_clear();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
